// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
//
// Load/store unit sitting between the execute unit (EXU) and the write-back
// unit (WBU). Each operation from the EXU is captured in a single-entry
// buffer. ALU operations pass straight through to the WBU one cycle after
// they are accepted. Loads and stores first issue one request on a simple
// req/ack memory port and then present their result to the WBU.
//
// Memory accesses are made on 8-byte aligned words. The low three address
// bits select the byte lane:
//   - stores shift their data and byte strobes into that lane;
//   - loads shift the returned word down, truncate it to the access size and
//     then sign- or zero-extend it.
//
// A flush empties the buffer. A flush that arrives while a memory request is
// outstanding cannot cancel that request. The unit therefore waits in a
// drain state until the ack arrives and throws the returned data away.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_flush            pipeline flush
//   i_pre_valid        EXU handshake: an operation is offered
//   o_pre_ready        EXU handshake: the LSU can take it
//   o_post_valid       WBU handshake: a result is offered
//   i_post_ready       WBU handshake: the WBU takes it
//   i_exu_exres        ALU result, also the effective address of loads/stores
//   i_exu_rs2          store data
//   i_exu_lden         operation is a load
//   i_exu_sten         operation is a store
//   i_exu_lsfunc       funct3 size/sign selector
//   i_exu_side         opaque sideband, forwarded unchanged
//   o_lsu_exres        buffered ALU result
//   o_lsu_lsres        extended load data
//   o_lsu_lden         buffered load flag
//   o_lsu_side         buffered sideband
//   o_mem_req          memory request, held until i_mem_ack
//   o_mem_wen          write enable (stores)
//   o_mem_addr         8-byte aligned word address
//   o_mem_wdata        lane-shifted store data
//   o_mem_wstrb        byte strobes
//   i_mem_ack          one-cycle completion pulse
//   i_mem_rdata        read data, valid together with i_mem_ack
// ---------------------------------------------------------------------------
module lsu #(
   parameter int CPU_WIDTH = 64,
   parameter int SIDE_W    = 128
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_pre_valid,
   output logic                 o_pre_ready,
   output logic                 o_post_valid,
   input  logic                 i_post_ready,
   input  logic [CPU_WIDTH-1:0] i_exu_exres,
   input  logic [CPU_WIDTH-1:0] i_exu_rs2,
   input  logic                 i_exu_lden,
   input  logic                 i_exu_sten,
   input  logic [2:0]           i_exu_lsfunc,
   input  logic [SIDE_W-1:0]    i_exu_side,
   output logic [SIDE_W-1:0]    o_lsu_side,
   output logic [CPU_WIDTH-1:0] o_lsu_exres,
   output logic [CPU_WIDTH-1:0] o_lsu_lsres,
   output logic                 o_lsu_lden,
   output logic                 o_mem_req,
   output logic                 o_mem_wen,
   output logic [CPU_WIDTH-1:0] o_mem_addr,
   output logic [CPU_WIDTH-1:0] o_mem_wdata,
   output logic [7:0]           o_mem_wstrb,
   input  logic                 i_mem_ack,
   input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MEM   = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } lsuState_t;

   lsuState_t              r_state;
   lsuState_t              w_nextState;

   logic [CPU_WIDTH-1:0]   r_exres;
   logic [CPU_WIDTH-1:0]   r_rs2;
   logic                   r_lden;
   logic                   r_sten;
   logic [2:0]             r_lsfunc;
   logic [SIDE_W-1:0]      r_side;
   logic [CPU_WIDTH-1:0]   r_lsres;

   logic                   w_load;
   logic                   w_clear;
   logic                   w_latchLs;
   logic [2:0]             w_offset;
   logic [5:0]             w_bitShift;
   logic [CPU_WIDTH-1:0]   w_rdShifted;
   logic [CPU_WIDTH-1:0]   w_loadData;
   logic [7:0]             w_baseStrb;

   // The memory request fields come straight from the buffer registers.
   // Those registers only change on accept or flush, and neither can happen
   // in MEM or DRAIN. So the request stays stable until the ack arrives.
   assign w_offset    = r_exres[2:0];
   assign w_bitShift  = {w_offset, 3'b000};
   assign o_mem_addr  = {r_exres[CPU_WIDTH-1:3], 3'b000};
   assign o_mem_wen   = r_sten;
   assign o_mem_wdata = r_sten ? (r_rs2 << w_bitShift) : '0;
   assign o_mem_wstrb = r_sten ? (w_baseStrb << w_offset) : 8'h00;

   assign o_lsu_exres = r_exres;
   assign o_lsu_lsres = r_lsres;
   assign o_lsu_lden  = r_lden;
   assign o_lsu_side  = r_side;

   assign w_rdShifted = i_mem_rdata >> w_bitShift;

   // Byte-strobe pattern for the access size. The two low funct3 bits encode
   // the size, so an unused encoding falls back to a full double-word.
   always_comb begin
      w_baseStrb = 8'hFF;
      case (r_lsfunc[1:0])
         2'b00:   w_baseStrb = 8'h01;
         2'b01:   w_baseStrb = 8'h03;
         2'b10:   w_baseStrb = 8'h0F;
         default: w_baseStrb = 8'hFF;
      endcase
   end

   // Truncate the lane-aligned read word to the access size and extend it.
   // Double-words and the unsigned variants are zero-extended. Byte, half and
   // word loads are sign-extended.
   always_comb begin
      w_loadData = w_rdShifted;
      case (r_lsfunc)
         3'b000:  w_loadData = {{(CPU_WIDTH-8){w_rdShifted[7]}},   w_rdShifted[7:0]};
         3'b001:  w_loadData = {{(CPU_WIDTH-16){w_rdShifted[15]}}, w_rdShifted[15:0]};
         3'b010:  w_loadData = {{(CPU_WIDTH-32){w_rdShifted[31]}}, w_rdShifted[31:0]};
         3'b100:  w_loadData = {{(CPU_WIDTH-8){1'b0}},  w_rdShifted[7:0]};
         3'b101:  w_loadData = {{(CPU_WIDTH-16){1'b0}}, w_rdShifted[15:0]};
         3'b110:  w_loadData = {{(CPU_WIDTH-32){1'b0}}, w_rdShifted[31:0]};
         default: w_loadData = w_rdShifted;
      endcase
   end

   // State register. Reset takes priority over everything, including an
   // outstanding memory request. Any ack that arrives after reset lands in
   // EMPTY, which ignores it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and handshake outputs.
   //   w_load    : capture a new operation from the EXU
   //   w_clear   : flush, which zeroes the data registers
   //   w_latchLs : capture load data when the ack arrives
   // A flush beats a simultaneous accept. In FULL, o_pre_ready follows
   // i_post_ready so that a new operation can enter in the same cycle the
   // old result leaves.
   always_comb begin
      w_nextState  = r_state;
      o_pre_ready  = 1'b0;
      o_post_valid = 1'b0;
      o_mem_req    = 1'b0;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      w_latchLs    = 1'b0;
      case (r_state)
         EMPTY: begin
            o_pre_ready = 1'b1;
            if (i_flush) begin
               w_clear     = 1'b1;
               w_nextState = EMPTY;
            end else if (i_pre_valid) begin
               w_load      = 1'b1;
               w_nextState = (i_exu_lden | i_exu_sten) ? MEM : FULL;
            end
         end
         MEM: begin
            o_mem_req = 1'b1;
            if (i_mem_ack) begin
               if (i_flush) begin
                  w_nextState = EMPTY;
               end else begin
                  w_latchLs   = r_lden;
                  w_nextState = FULL;
               end
            end else if (i_flush) begin
               w_nextState = DRAIN;
            end
         end
         FULL: begin
            o_post_valid = 1'b1;
            o_pre_ready  = i_post_ready;
            if (i_flush) begin
               w_clear     = 1'b1;
               w_nextState = EMPTY;
            end else if (i_post_ready) begin
               if (i_pre_valid) begin
                  w_load      = 1'b1;
                  w_nextState = (i_exu_lden | i_exu_sten) ? MEM : FULL;
               end else begin
                  w_nextState = EMPTY;
               end
            end
         end
         DRAIN: begin
            o_mem_req = 1'b1;
            if (i_mem_ack) begin
               w_nextState = EMPTY;
            end
         end
         default: begin
            w_nextState = EMPTY;
         end
      endcase
   end

   // Operation buffer. On accept, the load result register is cleared so
   // that a stale load value never travels with a later operation.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_exres  <= '0;
         r_rs2    <= '0;
         r_lden   <= 1'b0;
         r_sten   <= 1'b0;
         r_lsfunc <= 3'b000;
         r_side   <= '0;
         r_lsres  <= '0;
      end else if (w_clear) begin
         r_exres  <= '0;
         r_rs2    <= '0;
         r_lden   <= 1'b0;
         r_sten   <= 1'b0;
         r_lsfunc <= 3'b000;
         r_side   <= '0;
         r_lsres  <= '0;
      end else if (w_load) begin
         r_exres  <= i_exu_exres;
         r_rs2    <= i_exu_rs2;
         r_lden   <= i_exu_lden;
         r_sten   <= i_exu_sten;
         r_lsfunc <= i_exu_lsfunc;
         r_side   <= i_exu_side;
         r_lsres  <= '0;
      end else if (w_latchLs) begin
         r_lsres  <= w_loadData;
      end
   end

endmodule
